// File: rtl/pfb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : pfb_pkg
// Brief  : Shared FSM encoding, NOP constant and queue entry type for the
//          instruction prefetch buffer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package pfb_pkg;

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_fetch   = 2'd1;
   localparam logic [1:0] c_st_discard = 2'd2;

   localparam logic [31:0] c_nop     = 32'h0000_0013;
   localparam int          c_entry_w = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } pfb_entry_t;

endpackage
`default_nettype wire

// File: rtl/pfb_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : pfb_fifo
// Brief  : Synchronous DEPTH x WIDTH FIFO with flush and occupancy count.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module pfb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == (c_aw+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];

   // A pop frees the slot the same cycle, so push-on-full is accepted alongside it
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
   assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + (c_aw)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (c_aw)'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_buf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : instr_prefetch_buf
// Brief  : Single-outstanding-request instruction prefetch queue with redirect
//          flush. Define PFB_BYPASS_EN to forward a returning word straight to
//          the head outputs when the queue is empty.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module instr_prefetch_buf
   import pfb_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        instr_take,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int c_aw = $clog2(DEPTH);

   logic [1:0]    r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_discard_pc;

   pfb_entry_t    w_head;
   pfb_entry_t    w_wentry;
   logic          w_full;
   logic          w_empty;
   logic [c_aw:0] w_count;
   logic          w_fill;
   logic          w_byp;
   logic          w_byp_take;
   logic          w_push;
   logic          w_pop;
   logic [c_aw+1:0] w_cnt_after;
   logic          w_room;

   always_comb begin
`ifdef PFB_BYPASS_EN
      w_byp = (r_state == c_st_fetch) & mem_ready & ~redirect & w_empty;
`else
      w_byp = 1'b0;
`endif
      w_fill        = (r_state == c_st_fetch) & mem_ready & ~redirect;
      w_byp_take    = w_byp & instr_take;
      w_push        = w_fill & ~w_byp_take;
      w_pop         = instr_take & ~w_empty & ~redirect;
      w_wentry.pc   = r_fetch_pc;
      w_wentry.word = mem_data;
      // Occupancy once this cycle settles; the next request must fit behind it
      w_cnt_after   = {1'b0, w_count} + (c_aw+2)'(w_push) - (c_aw+2)'(w_pop);
      w_room        = (w_cnt_after < (c_aw+2)'(DEPTH));
   end

   pfb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (c_entry_w)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_wdata (w_wentry),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= c_st_idle;
         r_fetch_pc   <= RESET_PC;
         r_discard_pc <= RESET_PC;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
                  r_state    <= c_st_fetch;
               end else if (!w_full) begin
                  r_state    <= c_st_fetch;
               end
            end
            c_st_fetch: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
                  // Keep presenting the abandoned address until memory answers
                  if (!mem_ready) begin
                     r_discard_pc <= r_fetch_pc;
                     r_state      <= c_st_discard;
                  end
               end else if (mem_ready) begin
                  r_fetch_pc <= r_fetch_pc + 32'd4;
                  r_state    <= w_room ? c_st_fetch : c_st_idle;
               end
            end
            c_st_discard: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
               end
               if (mem_ready) begin
                  r_state <= c_st_fetch;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign mem_ren     = (r_state == c_st_fetch) | (r_state == c_st_discard);
   assign mem_addr    = (r_state == c_st_discard) ? r_discard_pc : r_fetch_pc;
   assign instr_valid = ~w_empty | w_byp;
   assign instr       = ~w_empty ? w_head.word : (w_byp ? mem_data : c_nop);
   assign instr_pc    = ~w_empty ? w_head.pc : r_fetch_pc;

endmodule
`default_nettype wire

// File: doc/instr_prefetch_buf.md
INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  32  fetch address to instruction memory controller.
REQ-006 mem_ren  output  1  fetch request; held high with stable mem_addr until mem_ready.
REQ-007 mem_ready  input  1  memory controller done; mem_data valid this cycle.
REQ-008 mem_data  input  32  fetched instruction word.
REQ-009 redirect  input  1  CPU PC write (branch/jump/trap); flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 instr_take  input  1  CPU consumes head entry this cycle.
REQ-012 instr_valid  output  1  head entry valid.
REQ-013 instr  output  32  head instruction word.
REQ-014 instr_pc  output  32  address of head instruction.

Function
REQ-015 SHALL hold at most one outstanding memory request; FSM states IDLE, FETCH, DISCARD.
REQ-016 IDLE -> FETCH when queue has a free slot counting the pending fill; mem_ren=1, mem_addr=fetch_pc.
REQ-017 FETCH with mem_ready=1 SHALL push {fetch_pc, mem_data}, fetch_pc += 4 (mod 2^32 wrap), then FETCH again if space remains, else IDLE.
REQ-018 mem_ren SHALL be 1 only in FETCH and DISCARD; mem_addr SHALL not change while mem_ren=1 and mem_ready=0.
REQ-019 redirect SHALL flush all entries same cycle, instr_valid=0 next cycle, fetch_pc <= redirect_pc.
REQ-020 redirect in FETCH with mem_ready=0 -> DISCARD: hold request until mem_ready, drop the returned word, then FETCH at redirect_pc.
REQ-021 redirect in FETCH coincident with mem_ready=1: drop the returned word, next state FETCH at redirect_pc.
REQ-022 redirect in DISCARD SHALL overwrite the pending target pc; state stays DISCARD.
REQ-023 redirect takes priority over instr_take and push in the same cycle.
REQ-024 instr_take with instr_valid=0 SHALL be ignored; simultaneous push and pop on a full queue SHALL be legal and preserve count.
REQ-025 instr/instr_pc SHALL be stable while instr_valid=1 and instr_take=0.
REQ-026 Full: no new request issued; empty: instr_valid=0, instr=32'h0000_0013 (NOP).

Reset
REQ-027 reset=1: state IDLE, queue empty, fetch_pc=RESET_PC, mem_ren=0, mem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=RESET_PC.
REQ-028 reset during an outstanding request SHALL abandon it; the controller is reset by the same signal.
REQ-029 First request SHALL assert in the cycle after reset deasserts.

Configuration
REQ-030 Macro PFB_BYPASS_EN defined: when queue empty and mem_ready=1 in FETCH, mem_data/fetch_pc SHALL appear on instr/instr_pc with instr_valid=1 the same cycle; if instr_take=1 the word is not pushed.
REQ-031 PFB_BYPASS_EN undefined: returned word always enqueued; earliest instr_valid one cycle after mem_ready.

Structure
REQ-032 Shared package pfb_pkg: FSM state encoding, NOP constant, entry width (64).
REQ-033 Sub-module pfb_fifo: synchronous DEPTH x 64 FIFO with push, pop, flush, full, empty, count.

Verification
REQ-034 Reset release, mem_ready pulsed 1 cycle after each request, instr_take=1 -> mem_addr 0,4,8,...; instr_pc 0,4,8 in order.
REQ-035 DEPTH=4, instr_take=0 -> exactly 4 fetches then mem_ren=0; one take -> one further fetch, at address 0x10.
REQ-036 redirect_pc=0x100 while request at 0x8 pending, mem_ready 3 cycles later -> word for 0x8 dropped, next mem_addr=0x100, first instr_pc=0x100.
REQ-037 redirect coincident with mem_ready and instr_take on a full queue -> queue empty next cycle, next request 0x100.
REQ-038 fetch_pc=0xFFFF_FFFC fetch -> next mem_addr=0x0000_0000.
REQ-039 With PFB_BYPASS_EN, empty queue, mem_ready and instr_take same cycle -> instr_valid=1 that cycle, count remains 0; without the macro -> instr_valid one cycle later.
